// File: rtl/approx_adder_pipe.sv
// Two-stage pipelined adder whose low APPROX_BITS bits can use approximate cells.
// It reports the distance of each result from the exact sum and keeps result/error statistics.
module approx_adder_pipe #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH:0]   err_dist,
  input  logic             stat_clr,
  output logic [31:0]      op_count,
  output logic [31:0]      err_count
);

  logic             s1_valid_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             cin_reg;
  logic [1:0]       mode_reg;

  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic [WIDTH:0]   err_reg;
  logic [31:0]      op_count_reg;
  logic [31:0]      err_count_reg;

  logic             s2_load;
  logic             s1_advance;
  logic             out_fire;

  logic [WIDTH-1:0] approx_mask;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;
  logic             carry_c;
  logic             maj_c;
  logic [WIDTH:0]   exact_sum;
  logic [WIDTH:0]   approx_full;
  logic [WIDTH:0]   err_next;

  assign s2_load    = !out_valid_reg || out_ready;
  assign s1_advance = s1_valid_reg && s2_load;
  assign in_ready   = !s1_valid_reg || s1_advance;
  assign out_fire   = out_valid_reg && out_ready;

  // Bits below APPROX_BITS may use approximate cells; the mask is elaboration-time constant.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign approx_mask[gi] = (gi < APPROX_BITS);
    end
  endgenerate

  // Ripple chain kept inside one process so the carry never forms a combinational net loop.
  always_comb begin
    carry_c  = cin_reg;
    maj_c    = 1'b0;
    sum_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      maj_c = (a_reg[i] & b_reg[i]) | (a_reg[i] & carry_c) | (b_reg[i] & carry_c);
      if (approx_mask[i] && mode_reg == 2'd1) begin
        sum_next[i] = ~maj_c;
        carry_c     = maj_c;
      end else if (approx_mask[i] && mode_reg == 2'd2) begin
        sum_next[i] = b_reg[i];
        carry_c     = a_reg[i];
      end else begin
        sum_next[i] = a_reg[i] ^ b_reg[i] ^ carry_c;
        carry_c     = maj_c;
      end
    end
    cout_next = carry_c;
  end

  assign exact_sum   = {1'b0, a_reg} + {1'b0, b_reg} + {{WIDTH{1'b0}}, cin_reg};
  assign approx_full = {cout_next, sum_next};
  assign err_next    = (approx_full >= exact_sum) ? (approx_full - exact_sum)
                                                  : (exact_sum - approx_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      cin_reg      <= 1'b0;
      mode_reg     <= 2'd0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        a_reg    <= a;
        b_reg    <= b;
        cin_reg  <= cin;
        mode_reg <= mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      err_reg       <= '0;
    end else if (s2_load) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        sum_reg  <= sum_next;
        cout_reg <= cout_next;
        err_reg  <= err_next;
      end
    end
  end

  // Clear takes priority over a same-cycle transfer; both counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_reg  <= '0;
      err_count_reg <= '0;
    end else if (stat_clr) begin
      op_count_reg  <= '0;
      err_count_reg <= '0;
    end else if (out_fire) begin
      if (op_count_reg != 32'hFFFF_FFFF) begin
        op_count_reg <= op_count_reg + 32'd1;
      end
      if (err_reg != '0 && err_count_reg != 32'hFFFF_FFFF) begin
        err_count_reg <= err_count_reg + 32'd1;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign err_dist  = err_reg;
  assign op_count  = op_count_reg;
  assign err_count = err_count_reg;

endmodule

// File: doc/approx_adder_pipe.md
APPROX_ADDER_PIPE -- requirements
Module: approx_adder_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand width; legal range 4..64.
REQ-002 SHALL provide parameter APPROX_BITS, default 4, number of LSBs built from approximate cells; legal range 0..WIDTH.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand transaction offered.
REQ-007 in_ready  output  1  block accepts transaction this cycle.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 cin  input  1  carry-in.
REQ-010 mode  input  2  cell type for LSB field: 0 exact, 1 type-2, 2 type-5, 3 exact.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  approximate sum.
REQ-014 cout  output  1  carry out of MSB of approximate chain.
REQ-015 err_dist  output  WIDTH+1  |{cout,sum} - exact {cout,sum}|.
REQ-016 stat_clr  input  1  synchronous clear of statistics counters.
REQ-017 op_count  output  32  results accepted since reset/clear.
REQ-018 err_count  output  32  accepted results with err_dist != 0.

Function
REQ-019 Bit i < APPROX_BITS, mode 1: cout_i = majority(a_i,b_i,c_i); sum_i = ~cout_i.
REQ-020 Bit i < APPROX_BITS, mode 2: sum_i = b_i; cout_i = a_i (c_i ignored).
REQ-021 Bits i >= APPROX_BITS, and all bits in modes 0/3: exact full-adder; carry into bit APPROX_BITS is cout of bit APPROX_BITS-1 (cin when APPROX_BITS=0).
REQ-022 Exact reference sum SHALL be a+b+cin computed in parallel, WIDTH+1 bits; err_dist is unsigned absolute difference, never wraps.
REQ-023 Two-stage pipeline: S1 registers a, b, cin, mode; S2 registers sum, cout, err_dist; mode SHALL be captured per transaction.
REQ-024 Transfer occurs on valid&&ready at rising clk; latency from input transfer to out_valid is exactly 2 cycles when out_ready held high.
REQ-025 S2 loads when S2 empty or (out_valid && out_ready); S1 loads when S1 empty or S1 moves to S2.
REQ-026 in_ready SHALL be combinational: !s1_valid || s1_advance; throughput one transaction per cycle with out_ready high.
REQ-027 While out_valid && !out_ready, sum, cout, err_dist SHALL hold stable; no transaction dropped or duplicated; max 2 in flight.
REQ-028 On each output transfer op_count += 1; err_count += 1 if err_dist != 0; both saturate at 0xFFFFFFFF.
REQ-029 stat_clr in same cycle as output transfer: clear wins, counters become 0.
REQ-030 APPROX_BITS = WIDTH: cout is carry of the approximate chain MSB; APPROX_BITS = 0: block is exact in every mode.

Reset
REQ-031 rst_n low SHALL asynchronously clear s1_valid, out_valid, sum, cout, err_dist, op_count, err_count to 0.
REQ-032 Transactions in flight when reset asserts SHALL be discarded; in_ready = 1 first cycle after rst_n deasserts.

Verification (WIDTH=8, APPROX_BITS=4)
REQ-033 mode 0, a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0, err_dist=0, out_valid 2 cycles after accept.
REQ-034 mode 2, a=0x03, b=0x05, cin=0 -> sum=0x05, cout=0, err_dist=3, err_count +1.
REQ-035 mode 1, a=0x01, b=0x01, cin=0 -> sum=0x0E, cout=0, err_dist=12.
REQ-036 out_ready=0, in_valid=1 for 4 cycles -> exactly 2 accepted, in_ready low thereafter, outputs stable; release out_ready -> results in order, no loss.
REQ-037 Force op_count to 0xFFFFFFFF via accepted stream -> stays saturated; stat_clr with simultaneous transfer -> both counters 0.
REQ-038 Assert rst_n low with 2 in flight -> out_valid=0 immediately, counters 0, no stale result after release.
